// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Round-robin arbiter and sequencer that shares one sequential multiplier
// between NREQ requesters. It accepts one operand pair at a time, launches
// the multiplier with a single-cycle start pulse, captures the product on
// done and returns it tagged with the requester index. A watchdog drops a
// job that never completes and reports it on err.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid         per-requester request
//   req_a, req_b      flattened operands, slice i is [i*N +: N]
//   req_ready         one-hot grant (combinational, only in IDLE)
//   rsp_valid         one-cycle response pulse
//   rsp_id            owner of the current/last job
//   rsp_product       product, held until the next response
//   err               one-cycle watchdog timeout pulse
//   mul_start         start pulse to the multiplier
//   mul_multiplicand  latched operand A
//   mul_multiplier    latched operand B
//   mul_product       multiplier result
//   mul_busy          multiplier busy
//   mul_done          multiplier completion pulse
// -----------------------------------------------------------------------------
module mult_arbiter #(
   parameter int N       = 32,
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 2*N+8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [2*N-1:0]    rsp_product,
   output logic              err,
   output logic              mul_start,
   output logic [N-1:0]      mul_multiplicand,
   output logic [N-1:0]      mul_multiplier,
   input  logic [2*N-1:0]    mul_product,
   input  logic              mul_busy,
   input  logic              mul_done
);

   localparam int WDW = $clog2(TIMEOUT+1);
   localparam logic [IDW-1:0] LAST = IDW'(NREQ-1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_after;
   logic [IDW-1:0] cand;
   logic [IDW-1:0] grant_idx;
   logic           grant_found;
   logic           hit;
   logic           accept;
   logic           timeout_hit;
   logic [N-1:0]   sel_a;
   logic [N-1:0]   sel_b;
   logic [WDW-1:0] wdog;

   // Round-robin search: first valid requester starting at ptr, wrapping at NREQ.
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      hit         = 1'b0;
      cand        = ptr;
      for (int k = 0; k < NREQ; k++) begin
         hit         = !grant_found && req_valid[cand];
         grant_idx   = hit ? cand : grant_idx;
         grant_found = grant_found | hit;
         cand        = (cand == LAST) ? '0 : cand + 1'b1;
      end
   end

   // Operand mux for the winning requester; only its slice is sampled.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_a = (grant_idx == IDW'(i)) ? req_a[i*N +: N] : sel_a;
         sel_b = (grant_idx == IDW'(i)) ? req_b[i*N +: N] : sel_b;
      end
   end

   // One-hot grant, only offered in IDLE while the multiplier is free.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = accept && (grant_idx == IDW'(i));
      end
   end

   assign accept      = (state == ST_IDLE) && !mul_busy && grant_found;
   // The watchdog counts WAIT cycles from 0; the last permitted cycle aborts.
   assign timeout_hit = (state == ST_WAIT) && !mul_done && (wdog == WDW'(TIMEOUT-1));
   // The served (or timed-out) requester gets the lowest priority next time.
   assign ptr_after   = (rsp_id == LAST) ? '0 : rsp_id + 1'b1;

   assign mul_start   = (state == ST_START);
   assign rsp_valid   = (state == ST_RESP);
   assign err         = timeout_hit;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  state_next = accept ? ST_START : ST_IDLE;
         ST_START: state_next = ST_WAIT;
         ST_WAIT: begin
            if (mul_done) begin
               state_next = ST_RESP;
            end else if (timeout_hit) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_WAIT;
            end
         end
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Operand/id latches, watchdog, product capture and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr              <= '0;
         rsp_id           <= '0;
         rsp_product      <= '0;
         mul_multiplicand <= '0;
         mul_multiplier   <= '0;
         wdog             <= '0;
      end else begin
         if (accept) begin
            mul_multiplicand <= sel_a;
            mul_multiplier   <= sel_b;
            rsp_id           <= grant_idx;
         end
         case (state)
            ST_START: wdog <= '0;
            ST_WAIT: begin
               wdog <= wdog + 1'b1;
               if (mul_done) begin
                  rsp_product <= mul_product;
               end
               if (timeout_hit) begin
                  ptr <= ptr_after;
               end
            end
            ST_RESP:  ptr <= ptr_after;
            default:  ;
         endcase
      end
   end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one `seq_multiplier` instance between NREQ requesters. It accepts one operand pair at a time through a valid/ready handshake and launches the multiplier with a single-cycle start pulse. It captures the product on `done` and returns it to the granted requester, tagged with the requester index. A watchdog aborts a multiplication that never completes. The block sits between the client ports and the shared multiplier datapath.

## Interface
- N, 32: operand width; product is 2N.
- NREQ, 4: number of requesters (2..8).
- IDW, 2: requester index width; must satisfy 2^IDW >= NREQ.
- TIMEOUT, 2*N+8: watchdog limit, in cycles spent in WAIT.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*N  flattened multiplicands; slice i is [i*N +: N].
- req_b  in  NREQ*N  flattened multipliers, same slicing as req_a.
- req_ready  out  NREQ  one-hot grant; a request is accepted on the edge where req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  one-cycle pulse; the response is valid.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_product  out  2N  product, held until the next response.
- err  out  1  one-cycle pulse on watchdog timeout; rsp_id carries the victim index.
- mul_start  out  1  start pulse to the multiplier.
- mul_multiplicand  out  N  latched operand A.
- mul_multiplier  out  N  latched operand B.
- mul_product  in  2N  multiplier result.
- mul_busy  in  1  multiplier busy.
- mul_done  in  1  multiplier completion pulse.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: req_ready is combinational and equals the one-hot of the first requester with req_valid high. The search begins at ptr and wraps modulo NREQ. req_ready is gated by !mul_busy and is all-zero in every other state.
  - On acceptance: latch req_a and req_b slice g into mul_multiplicand and mul_multiplier, latch g into rsp_id, then go to START.
- START: drive mul_start=1 for exactly this cycle, clear the watchdog, then go to WAIT. mul_done is ignored in this state.
- WAIT: increment the watchdog each cycle.
  - On mul_done=1: latch mul_product into rsp_product, then go to RESP.
  - If the watchdog reaches TIMEOUT-1 with no done: pulse err, set ptr = g+1 mod NREQ, then go to IDLE. rsp_product is unchanged.
- RESP: rsp_valid=1 for one cycle, set ptr = g+1 mod NREQ, then go to IDLE.
- Round robin: the most recently served requester has the lowest priority next time. After a timeout, the victim is treated as served.
- Operands and rsp_product are passed through unchanged; the arbiter performs no arithmetic on them.
- A requester may drop req_valid at any time before acceptance. Only the slice of the granted requester is sampled.
- Reset values: state=IDLE, ptr=0, req_ready=0 (combinational, from IDLE after reset), mul_start=0, operand latches=0, rsp_valid=0, rsp_id=0, rsp_product=0, err=0, watchdog=0.
- Reset asserted in any state returns the FSM to IDLE on the next edge. Any in-flight job is dropped with no rsp_valid and no err. The multiplier is reset by the same rst.

## Timing
- With acceptance at edge T:
  - mul_start is high in cycle T..T+1.
  - If mul_done is sampled high at edge D, rsp_valid and rsp_product are visible in the cycle after D.
  - The next grant is possible in the cycle after rsp_valid.
- Per-job overhead is 3 cycles plus the multiplier latency. Exactly one job is in flight.
- Simultaneous requests are served one per job in round-robin order from ptr. A requester that re-asserts req_valid immediately cannot be granted twice while another requester is waiting.
- mul_busy high in IDLE (for example, residual busy after reset) suppresses grants until it clears.
- mul_done high outside WAIT is ignored.

## Test plan
- Single request: requester 0 sends 10*5 → one grant, one mul_start pulse, rsp_valid with rsp_id=0 and rsp_product=50; err stays 0.
- Contention: all four requesters valid in the same cycle with (i+1)*1000 and 3 → responses in order id 0,1,2,3, with products 3000, 6000, 9000, 12000.
- Fairness: requesters 1 and 2 both hold req_valid continuously → grants alternate 1,2,1,2 over 8 jobs; no requester is granted twice in a row.
- Boundaries: 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE00000001; 12345*0 gives 0 → correct rsp_id on each response.
- Watchdog: stub the multiplier so mul_done is never asserted → err pulses exactly TIMEOUT cycles after START with rsp_id=victim, no rsp_valid, and the FSM returns to IDLE and grants the next requester.
- Reset mid-WAIT: assert rst 5 cycles after mul_start → all outputs are at reset values, no rsp_valid, and a following 7*6 request returns 42 with id 0.
